clock_divider_bank: RTL and testbench

CLOCK_DIVIDER_BANK -- requirements
Module: clock_divider_bank

---
 rtl/clock_divider_bank_if.sv | 30 +++
 rtl/clock_divider_bank.sv | 123 ++++++++++++
 tb/tb_clock_divider_bank.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/clock_divider_bank_if.sv
// Configuration write port of clock_divider_bank.
// Handshake: a write transfers on a clock edge where cfg_valid and cfg_ready are both 1.
interface clock_divider_bank_if #(
  parameter int CHANNELS = 4,
  parameter int CNTW     = 8
);
  localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic            cfg_valid;
  logic            cfg_ready;
  logic [CHW-1:0]  cfg_channel;
  logic [CNTW-1:0] cfg_divide;
  logic [CNTW:0]   cfg_phase;

  modport master (
    output cfg_valid,
    output cfg_channel,
    output cfg_divide,
    output cfg_phase,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_channel,
    input  cfg_divide,
    input  cfg_phase,
    output cfg_ready
  );
endinterface

// File: rtl/clock_divider_bank.sv
// Bank of programmable 50%-duty clock dividers sharing one settle/run controller;
// every accepted configuration write re-settles and restarts all channels phase-aligned.
module clock_divider_bank #(
  parameter int CHANNELS = 4,
  parameter int CNTW     = 8,
  parameter int SETTLE   = 16
) (
  input  logic                clock,
  input  logic                reset,
  clock_divider_bank_if.slave cfg,
  output logic                locked,
  output logic [CHANNELS-1:0] clock_o,
  output logic [CHANNELS-1:0] strobe_o,
  output logic                state_dbg
);
  localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int SW  = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
  localparam logic [SW-1:0]  SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [CHW:0]   CH_LIMIT    = CHANNELS[CHW:0];
  localparam logic [CNTW:0]  CNT_ONE     = (CNTW + 1)'(1);

  typedef enum logic {
    S_SETTLE = 1'b0,
    S_RUN    = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [SW-1:0]  settle_q, settle_d;
  logic           go_run;
  logic           write_en;
  logic           chan_ok;
  logic [CNTW:0]  phase_clamped;

  logic [CNTW-1:0] div_q    [CHANNELS];
  logic [CNTW:0]   phase_q  [CHANNELS];
  logic [CNTW:0]   cnt_q    [CHANNELS];
  logic [CNTW:0]   cnt_next [CHANNELS];

  assign chan_ok       = ({1'b0, cfg.cfg_channel} < CH_LIMIT);
  assign cfg.cfg_ready = (state_q == S_RUN);
  assign locked        = (state_q == S_RUN);
  assign state_dbg     = state_q;

  // A phase outside one period (or on a disabled channel) would never be reached by the counter.
  assign phase_clamped = ((cfg.cfg_divide == '0) || (cfg.cfg_phase >= {cfg.cfg_divide, 1'b0}))
                         ? '0 : cfg.cfg_phase;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_SETTLE;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    go_run   = 1'b0;
    write_en = 1'b0;
    case (state_q)
      S_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d  = S_RUN;
          settle_d = '0;
          go_run   = 1'b1;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      S_RUN: begin
        // Writes to a nonexistent channel are dropped without disturbing the running outputs.
        if (cfg.cfg_valid && chan_ok) begin
          write_en = 1'b1;
          state_d  = S_SETTLE;
          settle_d = '0;
        end
      end
      default: state_d = S_SETTLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_next[i] = (cnt_q[i] == ({div_q[i], 1'b0} - CNT_ONE)) ? '0 : cnt_q[i] + CNT_ONE;
    end
  end

  // Outputs are registered from the counter's next value so they stay aligned with cnt_q.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        div_q[i]   <= CNTW'(1);
        phase_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
      clock_o  <= '0;
      strobe_o <= '0;
    end else begin
      if (write_en) begin
        div_q[cfg.cfg_channel]   <= cfg.cfg_divide;
        phase_q[cfg.cfg_channel] <= phase_clamped;
      end
      for (int i = 0; i < CHANNELS; i++) begin
        if ((state_q == S_RUN) && !write_en && (div_q[i] != '0)) begin
          cnt_q[i]    <= cnt_next[i];
          clock_o[i]  <= (cnt_next[i] < {1'b0, div_q[i]});
          strobe_o[i] <= (cnt_next[i] == '0);
        end else if (go_run && (div_q[i] != '0)) begin
          cnt_q[i]    <= phase_q[i];
          clock_o[i]  <= (phase_q[i] < {1'b0, div_q[i]});
          strobe_o[i] <= (phase_q[i] == '0);
        end else begin
          cnt_q[i]    <= '0;
          clock_o[i]  <= 1'b0;
          strobe_o[i] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_clock_divider_bank.sv
// Directed bench for clock_divider_bank with CHANNELS=3, CNTW=8, SETTLE=16.
module tb_clock_divider_bank;
  logic       clock;
  logic       reset;
  logic       locked;
  logic [2:0] clock_o;
  logic [2:0] strobe_o;
  logic       state_dbg;

  int checks = 0;
  int errors = 0;
  int d_m [3];
  int p_m [3];

  clock_divider_bank_if #(.CHANNELS(3), .CNTW(8)) cfg_if ();

  clock_divider_bank #(.CHANNELS(3), .CNTW(8), .SETTLE(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .cfg       (cfg_if),
    .locked    (locked),
    .clock_o   (clock_o),
    .strobe_o  (strobe_o),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Expected outputs k cycles into RUN, from each channel's D and stored P.
  function automatic logic [2:0] exp_clk(input int k);
    logic [2:0] v;
    v = '0;
    for (int i = 0; i < 3; i++) begin
      if (d_m[i] > 0) v[i] = (((p_m[i] + k) % (2 * d_m[i])) < d_m[i]);
    end
    return v;
  endfunction

  function automatic logic [2:0] exp_stb(input int k);
    logic [2:0] v;
    v = '0;
    for (int i = 0; i < 3; i++) begin
      if (d_m[i] > 0) v[i] = (((p_m[i] + k) % (2 * d_m[i])) == 0);
    end
    return v;
  endfunction

  // driver
  task automatic write_cfg(input int ch, input int d, input int p, input int exp_p);
    logic [1:0] ch_v;
    logic [7:0] d_v;
    logic [8:0] p_v;
    ch_v = ch[1:0];
    d_v  = d[7:0];
    p_v  = p[8:0];
    cfg_if.cfg_valid   = 1'b1;
    cfg_if.cfg_channel = ch_v;
    cfg_if.cfg_divide  = d_v;
    cfg_if.cfg_phase   = p_v;
    step();
    cfg_if.cfg_valid = 1'b0;
    if (ch < 3) begin
      d_m[ch] = d;
      p_m[ch] = exp_p;
    end
  endtask

  task automatic settle_check(input string tag);
    for (int c = 0; c < 16; c++) begin
      chk({tag, "_locked"}, 32'(locked), 32'd0);
      chk({tag, "_ready"}, 32'(cfg_if.cfg_ready), 32'd0);
      chk({tag, "_clk"}, 32'(clock_o), 32'd0);
      chk({tag, "_stb"}, 32'(strobe_o), 32'd0);
      step();
    end
  endtask

  task automatic run_check(input string tag, input int k0, input int n);
    for (int k = k0; k < k0 + n; k++) begin
      chk({tag, "_locked"}, 32'(locked), 32'd1);
      chk({tag, "_ready"}, 32'(cfg_if.cfg_ready), 32'd1);
      chk({tag, "_clk"}, 32'(clock_o), 32'(exp_clk(k)));
      chk({tag, "_stb"}, 32'(strobe_o), 32'(exp_stb(k)));
      step();
    end
  endtask

  initial begin
    logic [7:0] pat;
    reset = 1'b1;
    cfg_if.cfg_valid   = 1'b0;
    cfg_if.cfg_channel = '0;
    cfg_if.cfg_divide  = '0;
    cfg_if.cfg_phase   = '0;
    for (int i = 0; i < 3; i++) begin
      d_m[i] = 1;
      p_m[i] = 0;
    end
    step();
    step();
    step();
    chk("reset_locked", 32'(locked), 32'd0);
    chk("reset_ready", 32'(cfg_if.cfg_ready), 32'd0);
    chk("reset_clk", 32'(clock_o), 32'd0);
    chk("reset_stb", 32'(strobe_o), 32'd0);
    chk("reset_state", 32'(state_dbg), 32'd0);

    // Release: 16 settle cycles then defaults D=1, P=0 on every channel.
    reset = 1'b0;
    settle_check("boot_settle");
    chk("boot_state", 32'(state_dbg), 32'd1);
    chk("boot_clk0", 32'(clock_o), 32'b111);
    chk("boot_stb0", 32'(strobe_o), 32'b111);
    step();
    chk("boot_clk1", 32'(clock_o), 32'b000);
    chk("boot_stb1", 32'(strobe_o), 32'b000);
    step();
    run_check("boot_run", 2, 6);

    // ch1 D=3 P=2: counter runs 2,3,4,5,0,1,...
    chk("w1_ready", 32'(cfg_if.cfg_ready), 32'd1);
    write_cfg(1, 3, 2, 2);
    settle_check("w1_settle");
    pat = '0;
    for (int k = 0; k < 8; k++) begin
      pat = {pat[6:0], clock_o[1]};
      chk("w1_others", 32'({clock_o[2], clock_o[0]}), 32'((k % 2 == 0) ? 2'b11 : 2'b00));
      chk("w1_stb1", 32'(strobe_o[1]), 32'((k == 4) ? 1 : 0));
      step();
    end
    chk("w1_pattern", 32'(pat), 32'b10001110);
    run_check("w1_run", 8, 12);

    // ch2 D=0 P=5: disabled, phase stored as 0.
    write_cfg(2, 0, 5, 0);
    settle_check("w2_settle");
    chk("w2_phase", 32'(dut.phase_q[2]), 32'd0);
    run_check("w2_run", 0, 12);

    // ch0 D=2 P=4: phase clamps to 0, pattern 1100.
    write_cfg(0, 2, 4, 0);
    settle_check("w3_settle");
    chk("w3_phase", 32'(dut.phase_q[0]), 32'd0);
    pat = '0;
    for (int k = 0; k < 8; k++) begin
      pat = {pat[6:0], clock_o[0]};
      step();
    end
    chk("w3_pattern", 32'(pat), 32'b11001100);
    run_check("w3_run", 8, 4);

    // Invalid channel 3 while running: nothing restarts.
    cfg_if.cfg_valid   = 1'b1;
    cfg_if.cfg_channel = 2'd3;
    cfg_if.cfg_divide  = 8'd5;
    cfg_if.cfg_phase   = 9'd1;
    run_check("w4_during", 12, 1);
    cfg_if.cfg_valid = 1'b0;
    run_check("w4_after", 13, 11);
    chk("w4_div0", 32'(dut.div_q[0]), 32'd2);

    // Reset in the middle of a settle discards the written configuration.
    write_cfg(1, 3, 0, 0);
    for (int c = 0; c < 8; c++) begin
      chk("w5_settle_locked", 32'(locked), 32'd0);
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d_m[i] = 1;
      p_m[i] = 0;
    end
    settle_check("w5_resettle");
    chk("w5_div1", 32'(dut.div_q[1]), 32'd1);
    run_check("w5_run", 0, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
